control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 93 +++++++++
 rtl/control_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// ----------------------------------------------------------------------------
// control_unit_if
//
// Purpose:
//   Groups the signals exchanged between the control unit and the program
//   management stage (plus the start request and the opcode coming back from
//   the instruction register). Clock and reset are plain module ports and are
//   not part of this bundle.
//
// Handshake semantics:
//   There is no valid/ready pair on this bundle. 'run' is a level request that
//   the control unit samples only while idle; 'opcode' is sampled only in the
//   decode state; every control output is a registered-state (Moore) decode
//   that is valid for the whole cycle in which the control unit sits in the
//   corresponding state.
//
// Signals:
//   run            - start request (slave -> master)
//   opcode[3:0]    - IR[15:12] (slave -> master)
//   writePC        - PC write enable
//   writeRA        - return-address write enable
//   PCsrc          - PC source select (0 = PC+1)
//   ImRPC          - immediate / relative PC select
//   Memsrc         - memory address source select
//   MemW1, MemW2   - memory port 1 / port 2 write enables
//   MemR1, MemR2   - memory port 1 / port 2 read enables
//   conditionalBop - conditional branch operation
//   restore        - restore PC from return address
//   regWrite       - register file write enable
//   aluGo          - ALU result capture enable
//   halted         - control unit is halted
//
// Modports:
//   master - the control unit (drives the control outputs)
//   slave  - the datapath / program management side
// ----------------------------------------------------------------------------
interface control_unit_if;
    logic       run;
    logic [3:0] opcode;

    logic       writePC;
    logic       writeRA;
    logic       PCsrc;
    logic       ImRPC;
    logic       Memsrc;
    logic       MemW1;
    logic       MemW2;
    logic       MemR1;
    logic       MemR2;
    logic       conditionalBop;
    logic       restore;
    logic       regWrite;
    logic       aluGo;
    logic       halted;

    modport master (
        input  run,
        input  opcode,
        output writePC,
        output writeRA,
        output PCsrc,
        output ImRPC,
        output Memsrc,
        output MemW1,
        output MemW2,
        output MemR1,
        output MemR2,
        output conditionalBop,
        output restore,
        output regWrite,
        output aluGo,
        output halted
    );

    modport slave (
        output run,
        output opcode,
        input  writePC,
        input  writeRA,
        input  PCsrc,
        input  ImRPC,
        input  Memsrc,
        input  MemW1,
        input  MemW2,
        input  MemR1,
        input  MemR2,
        input  conditionalBop,
        input  restore,
        input  regWrite,
        input  aluGo,
        input  halted
    );
endinterface

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
//
// Purpose:
//   Multi-cycle instruction sequencer. Walks FETCH -> DECODE -> EXEC ->
//   MEM -> WB as each opcode requires and produces the control strobes for
//   the program management stage, the register file and the ALU.
//
//   Supported opcodes (IR[15:12]):
//     0 ADD, 1 LW, 2 SW, 3 BEQ, 4 JAL, 5 JR, F HALT, anything else = NOP.
//
//   FETCH-to-FETCH cycle counts:
//     ADD 4, LW 5, SW 4, BEQ/JAL/JR 3, NOP 2.
//
// Ports:
//   clk         - system clock, all state changes on the rising edge
//   reset       - synchronous, active-high; forces S_IDLE and clears op_q
//   bus         - control_unit_if.master: run/opcode in, control strobes out
//   state       - debug view of the current FSM state encoding
//   instr_count - (only with CU_INSTR_COUNT_EN) 16-bit count of decoded
//                 non-halt instructions, wraps at 16'hFFFF
//
// Configuration:
//   CU_INSTR_COUNT_EN - when defined, adds the instr_count output and its
//                       counter; when undefined the port and counter are
//                       absent and all other behaviour is unchanged.
//
// Outputs are a pure decode of the registered state and the latched opcode
// (op_q); no input reaches an output combinationally.
// ----------------------------------------------------------------------------
module control_unit (
    input  logic                 clk,
    input  logic                 reset,
    control_unit_if.master       bus,
    output logic [2:0]           state
`ifdef CU_INSTR_COUNT_EN
    ,
    output logic [15:0]          instr_count
`endif
);

    // ------------------------------------------------------------------
    // State and opcode encodings
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_LW   = 4'h1;
    localparam logic [3:0] OP_SW   = 4'h2;
    localparam logic [3:0] OP_BEQ  = 4'h3;
    localparam logic [3:0] OP_JAL  = 4'h4;
    localparam logic [3:0] OP_JR   = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] op_q;

    // Decoded control strobes, driven onto the interface below.
    logic writePC_c;
    logic writeRA_c;
    logic PCsrc_c;
    logic ImRPC_c;
    logic Memsrc_c;
    logic MemW1_c;
    logic MemW2_c;
    logic MemR1_c;
    logic MemR2_c;
    logic conditionalBop_c;
    logic restore_c;
    logic regWrite_c;
    logic aluGo_c;
    logic halted_c;

    // Opcodes 0..5 are real instructions that need an EXEC cycle.
    logic opcode_is_instr;
    assign opcode_is_instr = (bus.opcode <= OP_JR);

    // ------------------------------------------------------------------
    // State register and opcode latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            // Capture the opcode on the edge leaving DECODE so EXEC/MEM/WB
            // see a stable value even if the IR moves on.
            if (state_q == S_DECODE) begin
                op_q <= bus.opcode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                state_d = bus.run ? S_FETCH : S_IDLE;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (bus.opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode_is_instr) begin
                    state_d = S_EXEC;
                end else begin
                    // Undefined opcodes behave as NOP: straight back to fetch.
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD:        state_d = S_WB;
                    OP_LW, OP_SW:  state_d = S_MEM;
                    default:       state_d = S_FETCH;  // BEQ / JAL / JR
                endcase
            end
            S_MEM: begin
                state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                // Only reset leaves HALT.
                state_d = S_HALT;
            end
            default: begin
                // The one spare encoding recovers to idle.
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (state + op_q only)
    // ------------------------------------------------------------------
    always_comb begin
        writePC_c        = 1'b0;
        writeRA_c        = 1'b0;
        PCsrc_c          = 1'b0;
        ImRPC_c          = 1'b0;
        Memsrc_c         = 1'b0;
        MemW1_c          = 1'b0;
        MemW2_c          = 1'b0;
        MemR1_c          = 1'b0;
        MemR2_c          = 1'b0;
        conditionalBop_c = 1'b0;
        restore_c        = 1'b0;
        regWrite_c       = 1'b0;
        aluGo_c          = 1'b0;
        halted_c         = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Instruction read on port 1 and PC <= PC + 1 (PCsrc = 0).
                MemR1_c   = 1'b1;
                writePC_c = 1'b1;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD, OP_LW, OP_SW: begin
                        aluGo_c = 1'b1;
                    end
                    OP_BEQ: begin
                        // The PM stage decides whether to take the branch.
                        conditionalBop_c = 1'b1;
                        PCsrc_c          = 1'b1;
                        ImRPC_c          = 1'b1;
                    end
                    OP_JAL: begin
                        writeRA_c = 1'b1;
                        writePC_c = 1'b1;
                        PCsrc_c   = 1'b1;
                        ImRPC_c   = 1'b1;
                    end
                    OP_JR: begin
                        restore_c = 1'b1;
                        writePC_c = 1'b1;
                        PCsrc_c   = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_MEM: begin
                // Data accesses always use port 2; port 1 is never written.
                if (op_q == OP_LW) begin
                    Memsrc_c = 1'b1;
                    MemR2_c  = 1'b1;
                end else if (op_q == OP_SW) begin
                    Memsrc_c = 1'b1;
                    MemW2_c  = 1'b1;
                end
            end
            S_WB: begin
                regWrite_c = 1'b1;
            end
            S_HALT: begin
                halted_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.writePC        = writePC_c;
    assign bus.writeRA        = writeRA_c;
    assign bus.PCsrc          = PCsrc_c;
    assign bus.ImRPC          = ImRPC_c;
    assign bus.Memsrc         = Memsrc_c;
    assign bus.MemW1          = MemW1_c;
    assign bus.MemW2          = MemW2_c;
    assign bus.MemR1          = MemR1_c;
    assign bus.MemR2          = MemR2_c;
    assign bus.conditionalBop = conditionalBop_c;
    assign bus.restore        = restore_c;
    assign bus.regWrite       = regWrite_c;
    assign bus.aluGo          = aluGo_c;
    assign bus.halted         = halted_c;

    assign state = state_q;

`ifdef CU_INSTR_COUNT_EN
    // ------------------------------------------------------------------
    // Instruction counter: one count per DECODE that does not halt
    // (real instructions and NOPs alike); wraps naturally at 16 bits.
    // ------------------------------------------------------------------
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'h0000;
        end else if (state_q == S_DECODE && bus.opcode != OP_HALT) begin
            count_q <= count_q + 16'h0001;
        end
    end

    assign instr_count = count_q;
`endif

endmodule
